reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file for the MIPS datapath: one write port, `NUM_RD` independent read ports, and a configurable depth and data width. It sits between decode and execute, feeds operands from the read ports and takes results from writeback. Reads are registered, `$zero` (entry 0) is hardwired to zero, and a sequential clear engine initialises every entry after reset, including the stack-pointer entry.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits.
- `DEPTH`, 32, number of entries; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `NUM_RD`, 2, number of read ports; 1..4.
- `SP_INDEX`, 29, entry loaded with `SP_INIT` by the clear engine.
- `SP_INIT`, 252, stack-pointer initial value: top of data memory.

Ports:
- `Clk`  in  1  clock; all state changes on rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `RegWrite`  in  1  write enable.
- `WriteRegister`  in  AW  write address.
- `WriteData`  in  DATA_W  write data.
- `ReadRegister`  in  NUM_RD*AW  packed read addresses; port p occupies bits [p*AW +: AW].
- `ReadData`  out  NUM_RD*DATA_W  packed registered read data; port p occupies bits [p*DATA_W +: DATA_W].
- `Busy`  out  1  high while the clear engine runs; writes are dropped while high.

## Operation
- FSM states: `CLEAR` and `RUN`.
- Rising edge with `Rst_n`=0:
  - state <= `CLEAR`, clear index <= 0.
  - `Busy` <= 1.
  - All `ReadData` lanes <= 0.
- `CLEAR` with `Rst_n`=1:
  - Each cycle writes entry[idx] <= (idx==SP_INDEX ? SP_INIT : 0), then idx++.
  - When idx == DEPTH-1 is written: state <= `RUN`, `Busy` <= 0.
- `CLEAR` read/write rules:
  - `RegWrite` is ignored.
  - Read lanes register 0.
- `RUN` writes: `RegWrite`=1 and `WriteRegister`≠0 gives entry[WriteRegister] <= `WriteData`. A write to entry 0 is discarded.
- `RUN` reads: each lane p registers entry[ReadRegister[p]]. Address 0 always yields 0.
- Same-cycle write and read to the same nonzero address: result depends on the `REGFILE_BYPASS_EN` macro (see Configuration).
- Lanes are fully independent. Any number of lanes may read the same address in the same cycle.
- Reset asserted during `CLEAR`: the clear index restarts at 0.
- Reset asserted during `RUN`: contents are re-initialised by a full clear sequence.
- `SP_INIT` is truncated to `DATA_W` bits.

## Timing
- Read latency: 1 cycle. The address presented at edge N appears on `ReadData` after edge N.
- Write: visible to a read sampled at edge N+1 or later after the write edge N. Visibility at edge N depends on the macro.
- Clear duration: exactly DEPTH cycles after the first edge with `Rst_n`=1. `Busy` falls after edge DEPTH.
- First accepted write: the edge on which `Busy` is 0.
- Reset values: `ReadData` = 0, `Busy` = 1.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined (write-first): a lane whose address equals `WriteRegister` (nonzero, `RegWrite`=1, `RUN`) registers `WriteData` on that edge.
- Undefined (read-first): that lane registers the old entry value, and the new value appears one cycle later.

## Structure
- Shared package `regfile_pkg`:
  - state enum (`CLEAR`, `RUN`).
  - default `DATA_W`, `DEPTH`, `NUM_RD`.
  - `SP_INDEX`, `SP_INIT`.
- Sub-module `reg_file_clear_fsm`:
  - holds the state and clear index.
  - outputs `Busy`, clear write enable, clear address and clear data.
  - the top level muxes its outputs onto the single write port.
- Read lanes are built with a generate loop.

## Test plan
- Reset, then release: `Busy`=1 for exactly 32 cycles. Afterwards, reading entry 29 gives 252 and entries 1..31 (excluding 29) give 0.
- `RUN`, write entry 5 = 0xDEADBEEF, read entry 5 on the next edge on both lanes: both give 0xDEADBEEF one cycle later.
- Write entry 0 = 0xFFFFFFFF, then read entry 0: result is 0.
- Same-edge write entry 7 = 0x1234 while lane 0 reads 7 (old value 0):
  - with macro: lane 0 gives 0x1234.
  - without macro: lane 0 gives 0, then 0x1234 on the next cycle.
- Write during `Busy` (cycle 3 of clear, entry 31 = 0xAA): after clear, entry 31 reads 0.
- Reset asserted at clear cycle 10 and again mid-`RUN` after writing entry 2 = 5: the clear sequence restarts (32 cycles), and entry 2 then reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state type and default parameters for reg_file_mp
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int SP_INDEX_DEF = 29;
  localparam int SP_INIT_DEF  = 252;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// rtl/reg_file_clear_fsm.sv - post-reset clear engine walking every entry once
module reg_file_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SP_INDEX = SP_INDEX_DEF,
  parameter int SP_INIT  = SP_INIT_DEF,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [AW-1:0]     clr_addr,
  output logic [DATA_W-1:0] clr_data
);

  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
  localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     SP_IDX   = AW'(SP_INDEX);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  // state register: reset always restarts the walk from entry 0
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // one entry per cycle while clearing; the stack pointer gets its initial value
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_we    = 1'b0;
    clr_addr  = idx;
    clr_data  = '0;
    case (state)
      CLEAR: begin
        clr_we   = Rst_n;
        clr_data = (idx == SP_IDX) ? SP_VAL : '0;
        if (idx == LAST_IDX) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign busy = (state == CLEAR);

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file; REGFILE_BYPASS_EN selects write-first reads
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int SP_INDEX = SP_INDEX_DEF,
  parameter int SP_INIT  = SP_INIT_DEF,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     RegWrite,
  input  logic [AW-1:0]            WriteRegister,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*AW-1:0]     ReadRegister,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic                     Busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [AW-1:0]     clr_addr;
  logic [DATA_W-1:0] clr_data;

  logic              run_we;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  reg_file_clear_fsm #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SP_INDEX (SP_INDEX),
    .SP_INIT  (SP_INIT),
    .AW       (AW)
  ) u_clear (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data)
  );

  // user writes only count once clearing is done, and never land on $zero
  assign run_we = !Busy && RegWrite && (WriteRegister != '0);

  // the clear engine owns the single write port while busy
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = WriteRegister;
    wr_data = WriteData;
    if (Busy) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_data = clr_data;
    end else begin
      wr_en = run_we && Rst_n;
    end
  end

  // storage array; contents come from the clear engine rather than reset
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd_q;

    assign ra = ReadRegister[p*AW +: AW];

    // registered read lane; $zero and the clearing window read as 0
    always_ff @(posedge Clk) begin
      if (!Rst_n) begin
        rd_q <= '0;
      end else if (Busy || (ra == '0)) begin
        rd_q <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (run_we && (WriteRegister == ra)) begin
        rd_q <= WriteData;
`endif
      end else begin
        rd_q <= mem[ra];
      end
    end

    assign ReadData[p*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int SPI   = 29;
  localparam int SPV   = 252;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [DW-1:0]     WriteData;
  logic [NRD*AW-1:0] ReadRegister;
  logic [NRD*DW-1:0] ReadData;
  logic              Busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m [DEPTH];
  int            clr_left;

  always #5 Clk = ~Clk;

  reg_file_mp #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NUM_RD   (NRD),
    .SP_INDEX (SPI),
    .SP_INIT  (SPV)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .Busy          (Busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic rst_n, input logic we, input int wa, input logic [DW-1:0] wd,
                      input int ra0, input int ra1, input string tag);
    logic [DW-1:0] exp [NRD];
    int            ra [NRD];
    ra[0] = ra0;
    ra[1] = ra1;
    Rst_n         = rst_n;
    RegWrite      = we;
    WriteRegister = wa[AW-1:0];
    WriteData     = wd;
    ReadRegister  = {ra1[AW-1:0], ra0[AW-1:0]};
    if (!rst_n) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      m[SPI] = SPV;
      for (int p = 0; p < NRD; p++) exp[p] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      for (int p = 0; p < NRD; p++) exp[p] = '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        exp[p] = m[ra[p]];
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 0 && wa == ra[p]) exp[p] = wd;
`endif
        if (ra[p] == 0) exp[p] = '0;
      end
      if (we && wa != 0) m[wa] = wd;
    end
    @(posedge Clk);
    @(negedge Clk);
    for (int p = 0; p < NRD; p++)
      check($sformatf("%s.rd%0d", tag, p), ReadData[p*DW +: DW], exp[p]);
    check($sformatf("%s.busy", tag), DW'(Busy), DW'(clr_left > 0));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 0, '0, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), tag);
  endtask

  initial begin
    step(1'b0, 1'b0, 0, '0, 0, 0, "reset");
    step(1'b0, 1'b1, 3, 32'h55, 3, 4, "reset");
    for (int c = 0; c < DEPTH; c++)
      step(1'b1, (c == 2), 31, 32'hAA, c, DEPTH-1-c, "clear");
    for (int a = 0; a < DEPTH; a++)
      step(1'b1, 1'b0, 0, '0, a, DEPTH-1-a, "init");

    step(1'b1, 1'b1, 5, 32'hDEADBEEF, 1, 2, "wr5");
    step(1'b1, 1'b0, 0, '0, 5, 5, "rd5");
    step(1'b1, 1'b1, 0, 32'hFFFFFFFF, 3, 4, "wr0");
    step(1'b1, 1'b0, 0, '0, 0, 0, "rd0");
    step(1'b1, 1'b1, 7, 32'h1234, 7, 7, "same7");
    step(1'b1, 1'b0, 0, '0, 7, 1, "after7");

    step(1'b1, 1'b1, 2, 32'h5, 2, 3, "wr2");
    step(1'b1, 1'b0, 0, '0, 2, 2, "rd2");
    step(1'b0, 1'b0, 0, '0, 2, 2, "rst_run");
    idle(10, "clr10");
    step(1'b0, 1'b0, 0, '0, 2, 2, "rst_clr");
    idle(DEPTH, "reclear");
    step(1'b1, 1'b0, 0, '0, 2, SPI, "rd2_clr");

    for (int i = 0; i < 600; i++) begin
      logic rn;
      int   wa, r0, r1;
      rn = ($urandom_range(0, 299) != 0);
      wa = $urandom_range(0, DEPTH-1);
      r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH-1);
      r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      step(rn, 1'($urandom_range(0, 1)), wa, $urandom, r0, r1, "rand");
    end
    idle(DEPTH + 2, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
